// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: buffered UART transmitter with per-frame configuration.
// A small write FIFO feeds a START/DATA/PARITY/STOP serialiser. The baud tick
// comes from a shared generator and provides COUNT_TICKS pulses per line bit.
// The data length, parity mode and stop count are latched when a word is
// popped, so a configuration change only affects frames that start later.
module uart_tx_cfg #(
    parameter int N           = 8,
    parameter int COUNT_TICKS = 16,
    parameter int FIFO_AW     = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               wr_en,
    input  logic [N-1:0]       data_in,
    input  logic [3:0]         cfg_data_bits,
    input  logic [1:0]         cfg_parity,
    input  logic               cfg_stop2,
    output logic               full,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               overflow,
    output logic               tx_busy,
    output logic               tx_done,
    output logic               tx
);

    localparam int DEPTH = 1 << FIFO_AW;
    // The tick counter must reach 2*COUNT_TICKS-1 when two stop bits are sent.
    localparam int TW = $clog2(2 * COUNT_TICKS);
    localparam logic [FIFO_AW:0] DEPTH_C  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [TW-1:0]    LAST_ONE = TW'(COUNT_TICKS - 1);
    localparam logic [TW-1:0]    LAST_TWO = TW'(2 * COUNT_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [N-1:0]       r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_overflow;

    // Serialiser state
    state_t             r_state;
    logic [TW-1:0]      r_ticks;
    logic [3:0]         r_bit;
    logic [N-1:0]       r_shift;
    logic [3:0]         r_nbits;
    logic               r_par_en;
    logic               r_par_odd;
    logic               r_stop2;
    logic               r_par_acc;
    logic               r_tx;
    logic               r_tx_done;

    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic [3:0]         w_nbits;
    logic               w_bit_end;
    logic               w_stop_end;

    assign w_full = (r_count == DEPTH_C);
    // A write into a full FIFO is dropped even when a pop frees a slot in
    // the same cycle; the producer is expected to honour full.
    assign w_push = wr_en && !w_full;
    assign w_pop  = (r_state == S_IDLE) && (r_count != '0);

    assign w_bit_end  = tick && (r_ticks == LAST_ONE);
    assign w_stop_end = tick && (r_ticks == (r_stop2 ? LAST_TWO : LAST_ONE));

    // Clamp the requested data length into the supported 5..N range
    always_comb begin
        if (cfg_data_bits < 4'd5) begin
            w_nbits = 4'd5;
        end else if (cfg_data_bits > 4'(N)) begin
            w_nbits = 4'(N);
        end else begin
            w_nbits = cfg_data_bits;
        end
    end

    // FIFO word storage, written without reset so it maps onto RAM
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // FIFO pointers, occupancy and the dropped-write pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= wr_en && w_full;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Frame sequencer; tx is registered from the current state, so the line
    // lags the state by one clock
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ticks   <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_nbits   <= 4'd5;
            r_par_en  <= 1'b0;
            r_par_odd <= 1'b0;
            r_stop2   <= 1'b0;
            r_par_acc <= 1'b0;
            r_tx      <= 1'b1;
            r_tx_done <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    // Ticks are ignored here; a waiting word starts at once
                    if (w_pop) begin
                        r_shift   <= r_mem[r_rd_ptr];
                        r_nbits   <= w_nbits;
                        r_par_en  <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
                        r_par_odd <= (cfg_parity == 2'b10);
                        r_stop2   <= cfg_stop2;
                        r_par_acc <= 1'b0;
                        r_ticks   <= '0;
                        r_bit     <= '0;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    r_tx <= 1'b0;
                    if (w_bit_end) begin
                        r_ticks <= '0;
                        r_state <= S_DATA;
                    end else if (tick) begin
                        r_ticks <= r_ticks + 1'b1;
                    end
                end
                S_DATA: begin
                    r_tx <= r_shift[0];
                    if (w_bit_end) begin
                        r_ticks   <= '0;
                        r_shift   <= r_shift >> 1;
                        r_par_acc <= r_par_acc ^ r_shift[0];
                        if (r_bit == r_nbits - 4'd1) begin
                            r_bit   <= '0;
                            r_state <= r_par_en ? S_PARITY : S_STOP;
                        end else begin
                            r_bit <= r_bit + 4'd1;
                        end
                    end else if (tick) begin
                        r_ticks <= r_ticks + 1'b1;
                    end
                end
                S_PARITY: begin
                    // Accumulated XOR gives even parity; odd inverts it
                    r_tx <= r_par_acc ^ r_par_odd;
                    if (w_bit_end) begin
                        r_ticks <= '0;
                        r_state <= S_STOP;
                    end else if (tick) begin
                        r_ticks <= r_ticks + 1'b1;
                    end
                end
                S_STOP: begin
                    r_tx <= 1'b1;
                    // Two stop bits are sent as one double-length stop period
                    if (w_stop_end) begin
                        r_ticks   <= '0;
                        r_tx_done <= 1'b1;
                        r_state   <= S_IDLE;
                    end else if (tick) begin
                        r_ticks <= r_ticks + 1'b1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign full       = w_full;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign tx_busy    = (r_state != S_IDLE);
    assign tx_done    = r_tx_done;
    assign tx         = r_tx;

endmodule
